// File: rtl/lsu_mem_align_pkg.sv
// lsu_mem_align_pkg: load/store funct3 encodings and LSU fault codes shared by the LSU stage.
package lsu_mem_align_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {FLT_NONE, FLT_MISALIGN, FLT_ILLEGAL, FLT_TIMEOUT} fault_e;
endpackage

// File: rtl/lsu_lane_steer.sv
// lsu_lane_steer: byte-lane steering (be, replicated store data, read shift) and access legality checks.
module lsu_lane_steer
  import lsu_mem_align_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [1:0]  roff,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_shift,
  output logic        misalign,
  output logic        illegal
);
  logic [1:0] size;
  assign size = funct3[1:0];
  assign illegal = (is_load & is_store)
                 | (is_load & !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
                 | (is_store & !(funct3 inside {F3_SB, F3_SH, F3_SW}));
  assign misalign = (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
  assign be = size == 2'b00 ? 4'b0001 << off : size == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign wdata_lane = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign rdata_shift = rdata >> {roff, 3'b000};
endmodule

// File: rtl/lsu_mem_align.sv
// lsu_mem_align: load/store access stage with alignment checks and a word-addressed memory port.
// Optional mem_ack timeout (fault 11) is built when LSU_TIMEOUT_EN is defined.
module lsu_mem_align
  import lsu_mem_align_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_is_load,
  input  logic        lsu_is_store,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [1:0]  lsu_fault,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [2:0]  ld_funct3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state;
  logic [1:0] off_q;
  logic load_q, accept, misalign, illegal, expire;
  logic [3:0] be;
  logic [31:0] wdata_lane, rdata_shift;
  assign lsu_ready = state == IDLE;
  assign accept = lsu_valid & lsu_ready & (lsu_is_load | lsu_is_store);
  lsu_lane_steer u_steer (
    .off(lsu_addr[1:0]), .funct3(lsu_funct3), .is_load(lsu_is_load), .is_store(lsu_is_store),
    .wdata(lsu_wdata), .roff(off_q), .rdata(mem_rdata), .be(be), .wdata_lane(wdata_lane),
    .rdata_shift(rdata_shift), .misalign(misalign), .illegal(illegal)
  );
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expire = !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  // Held at zero outside BUSY so every access starts counting from zero.
  always_ff @(posedge clk) cnt <= (rst || state != BUSY) ? '0 : cnt + 1'b1;
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      off_q <= '0;
      load_q <= 1'b0;
      lsu_done <= 1'b0;
      lsu_fault <= FLT_NONE;
      ld_valid <= 1'b0;
      ld_data <= '0;
      ld_funct3 <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          off_q <= lsu_addr[1:0];
          load_q <= lsu_is_load;
          ld_funct3 <= lsu_funct3;
          mem_we <= lsu_is_store;
          mem_addr <= {lsu_addr[31:2], 2'b00};
          mem_be <= be;
          mem_wdata <= wdata_lane;
          state <= (illegal | misalign) ? DONE : BUSY;
          mem_req <= !(illegal | misalign);
          lsu_done <= illegal | misalign;
          lsu_fault <= illegal ? FLT_ILLEGAL : misalign ? FLT_MISALIGN : FLT_NONE;
        end
        BUSY: if (mem_ack | expire) begin
          state <= DONE;
          mem_req <= 1'b0;
          lsu_done <= 1'b1;
          lsu_fault <= mem_ack ? FLT_NONE : FLT_TIMEOUT;
          ld_valid <= mem_ack & load_q;
          if (mem_ack & load_q) ld_data <= rdata_shift;
        end
        DONE: begin
          state <= IDLE;
          lsu_done <= 1'b0;
          lsu_fault <= FLT_NONE;
          ld_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
